// File: rtl/seg7_glyph_driver.sv
// seg7_glyph_driver
//
// Drives six active-low seven-segment digits from glyph codes supplied by a
// message sequencer. Codes are captured on load, decoded to segment patterns,
// and gated by a per-digit blink, a 15-step PWM brightness control and a
// global blank before being registered onto the outputs.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   load         capture code0..code5 this cycle
//   code0..code5 4-bit glyph codes (0-9 digits, 10 G, 11 b, 12 U, 13 F,
//                14 S, 15 blank)
//   blink_mask   bit i set makes digit i blink
//   brightness   duty level 0..15 (0 dark, 15 fully lit)
//   blank        force all digits dark
//   load_ack     one-cycle pulse the cycle after a capture
//   hex0..hex5   active-low segments, bit6..bit0 = g,f,e,d,c,b,a
module seg7_glyph_driver #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] code0,
    input  logic [3:0] code1,
    input  logic [3:0] code2,
    input  logic [3:0] code3,
    input  logic [3:0] code4,
    input  logic [3:0] code5,
    input  logic [5:0] blink_mask,
    input  logic [3:0] brightness,
    input  logic       blank,
    output logic       load_ack,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5
);

    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic [3:0]       code_reg [6];
    logic [6:0]       hex_reg  [6];
    logic [6:0]       hex_next [6];
    logic [3:0]       code_in  [6];
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;
    logic [3:0]       pwm_cnt;
    logic             pwm_on;

    assign code_in[0] = code0;
    assign code_in[1] = code1;
    assign code_in[2] = code2;
    assign code_in[3] = code3;
    assign code_in[4] = code4;
    assign code_in[5] = code5;

    assign hex0 = hex_reg[0];
    assign hex1 = hex_reg[1];
    assign hex2 = hex_reg[2];
    assign hex3 = hex_reg[3];
    assign hex4 = hex_reg[4];
    assign hex5 = hex_reg[5];

    // Glyph table, active-low segments g..a.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            4'd10:   seg = 7'h42;
            4'd11:   seg = 7'h03;
            4'd12:   seg = 7'h41;
            4'd13:   seg = 7'h0E;
            4'd14:   seg = 7'h12;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    // Code capture and acknowledge. Capture is independent of any display
    // gating so a load coinciding with blank or a blink wrap is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) code_reg[i] <= 4'd15;
            load_ack <= 1'b0;
        end else begin
            if (load) begin
                for (int i = 0; i < 6; i++) code_reg[i] <= code_in[i];
            end
            load_ack <= load;
        end
    end

    // Blink timebase: the phase flips each time the counter wraps, giving a
    // half-period of BLINK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // PWM counter runs 0..14 so brightness 15 is never reached and stays lit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= 4'd0;
        end else if (pwm_cnt == 4'd14) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign pwm_on = (pwm_cnt < brightness);

    // Output gating priority: blank, then PWM off-time, then per-digit blink.
    // Inputs are used directly here so their effect appears after a single
    // registered stage.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            hex_next[i] = decode(code_reg[i]);
            if (blank || !pwm_on || (blink_phase && blink_mask[i])) begin
                hex_next[i] = SEG_OFF;
            end
        end
    end

    // Registered segment outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) hex_reg[i] <= SEG_OFF;
        end else begin
            for (int i = 0; i < 6; i++) hex_reg[i] <= hex_next[i];
        end
    end

endmodule

// File: tb/tb_seg7_glyph_driver.sv
// tb_seg7_glyph_driver
//
// Self-checking bench for seg7_glyph_driver. A behavioural model tracks the
// number of cycles since reset and derives blink phase and PWM position from
// it arithmetically; a compare process checks every output on each falling
// edge. A few literal expectations pin the model to known values.
module tb_seg7_glyph_driver;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] cin [6];
    logic [5:0] blink_mask;
    logic [3:0] brightness;
    logic       blank;
    logic       load_ack;
    logic [6:0] hout [6];

    int compared;
    int mismatched;

    seg7_glyph_driver #(.BLINK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .code0      (cin[0]),
        .code1      (cin[1]),
        .code2      (cin[2]),
        .code3      (cin[3]),
        .code4      (cin[4]),
        .code5      (cin[5]),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .blank      (blank),
        .load_ack   (load_ack),
        .hex0       (hout[0]),
        .hex1       (hout[1]),
        .hex2       (hout[2]),
        .hex3       (hout[3]),
        .hex4       (hout[4]),
        .hex5       (hout[5])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyph table taken straight from the segment chart.
    logic [6:0] glyph [16];
    initial begin
        glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
        glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
        glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h42; glyph[11] = 7'h03;
        glyph[12] = 7'h41; glyph[13] = 7'h0E; glyph[14] = 7'h12; glyph[15] = 7'h7F;
    end

    // Behavioural model: t counts edges since reset, so the blink phase is
    // (t / DIV) odd and the PWM position is t mod 15.
    int         t;
    bit         model_valid;
    logic [3:0] mcode [6];
    logic [6:0] mhex  [6];
    logic       mack;

    initial model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            for (int i = 0; i < 6; i++) begin
                mcode[i] = 4'd15;
                mhex[i]  = 7'h7F;
            end
            mack = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            for (int i = 0; i < 6; i++) begin
                if (blank)
                    mhex[i] = 7'h7F;
                else if ((t % 15) >= int'(brightness))
                    mhex[i] = 7'h7F;
                else if (((t / DIV) % 2 == 1) && blink_mask[i])
                    mhex[i] = 7'h7F;
                else
                    mhex[i] = glyph[mcode[i]];
            end
            mack = load;
            if (load) for (int i = 0; i < 6; i++) mcode[i] = cin[i];
            t = t + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [6:0] actual,
                               input logic [6:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 6; i++)
                checkOutput($sformatf("model hex%0d", i), hout[i], mhex[i]);
            checkOutput("model load_ack", {6'd0, load_ack}, {6'd0, mack});
        end
    end

    task automatic applyStimulus(input logic r, input logic ld, input logic [3:0] c0,
                                 input logic [3:0] c1, input logic [3:0] c2,
                                 input logic [3:0] c3, input logic [3:0] c4,
                                 input logic [3:0] c5, input logic [5:0] mask,
                                 input logic [3:0] br, input logic bl);
        rst = r; load = ld;
        cin[0] = c0; cin[1] = c1; cin[2] = c2; cin[3] = c3; cin[4] = c4; cin[5] = c5;
        blink_mask = mask; brightness = br; blank = bl;
        @(negedge clk);
    endtask

    initial begin
        int lit;
        logic [6:0] want [6];
        compared = 0;
        mismatched = 0;
        rst = 1'b1; load = 1'b0; blank = 1'b0; blink_mask = '0; brightness = 4'd15;
        for (int i = 0; i < 6; i++) cin[i] = 4'd0;
        @(negedge clk);

        // Reset with load asserted: the load must be discarded.
        applyStimulus(1, 1, 1, 2, 3, 4, 5, 6, 6'h00, 4'd15, 0);
        for (int i = 0; i < 6; i++) checkOutput("reset hex", hout[i], 7'h7F);
        checkOutput("reset load_ack", {6'd0, load_ack}, 7'd0);

        // Idle after reset: still blank glyphs, no ack.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 4'd15, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 4'd15, 0);
        checkOutput("post-reset hex0", hout[0], 7'h7F);
        checkOutput("post-reset load_ack", {6'd0, load_ack}, 7'd0);

        // Message load: ack after the capture edge, glyphs one edge later.
        applyStimulus(0, 1, 10, 0, 15, 11, 12, 13, 6'h00, 4'd15, 0);
        checkOutput("msg load_ack", {6'd0, load_ack}, 7'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 4'd15, 0);
        want[0] = 7'h42; want[1] = 7'h40; want[2] = 7'h7F;
        want[3] = 7'h03; want[4] = 7'h41; want[5] = 7'h0E;
        for (int i = 0; i < 6; i++) checkOutput($sformatf("msg hex%0d", i), hout[i], want[i]);
        checkOutput("msg load_ack drop", {6'd0, load_ack}, 7'd0);

        // Sweep all codes on digit 0.
        for (int c = 0; c < 16; c++)
            applyStimulus(0, 1, 4'(c), 0, 0, 0, 0, 0, 6'h00, 4'd15, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 4'd15, 0);

        // Blink digit 0 showing an 8.
        applyStimulus(0, 1, 8, 1, 2, 3, 4, 5, 6'h01, 4'd15, 0);
        for (int k = 0; k < 20; k++)
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h01, 4'd15, 0);

        // Brightness 5: lit in exactly 5 of every 15 cycles.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 4'd5, 0);
        lit = 0;
        for (int k = 0; k < 15; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 4'd5, 0);
            if (hout[0] == 7'h00) lit++;
        end
        checkOutput("pwm lit count 5", 7'(lit), 7'd5);
        lit = 0;
        for (int k = 0; k < 15; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 4'd0, 0);
            if (hout[0] != 7'h7F) lit++;
        end
        checkOutput("pwm lit count 0", 7'(lit), 7'd0);

        // Blank pulse coincident with a load.
        applyStimulus(0, 1, 3, 3, 3, 3, 3, 3, 6'h00, 4'd15, 1);
        for (int i = 0; i < 6; i++) checkOutput("blank hex", hout[i], 7'h7F);
        checkOutput("blank load_ack", {6'd0, load_ack}, 7'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 4'd15, 0);
        for (int i = 0; i < 6; i++) checkOutput("after blank hex", hout[i], 7'h30);

        // Reset together with load mid-display.
        applyStimulus(1, 1, 1, 1, 1, 1, 1, 1, 6'h00, 4'd15, 0);
        for (int i = 0; i < 6; i++) checkOutput("rst+load hex", hout[i], 7'h7F);
        checkOutput("rst+load load_ack", {6'd0, load_ack}, 7'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 4'd15, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 4'd15, 0);
        for (int i = 0; i < 6; i++) checkOutput("rst+load codes 15", hout[i], 7'h7F);

        // Randomised traffic, including occasional resets.
        for (int k = 0; k < 400; k++)
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                          4'($urandom), 4'($urandom), 4'($urandom),
                          4'($urandom), 4'($urandom), 4'($urandom),
                          6'($urandom), 4'($urandom),
                          ($urandom_range(0, 7) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
